// File: rtl/mxv_pkg.sv
// Shared types and constants for the MxV datapath (shift register, serializer, controller).
package mxv_pkg;

    // Default bits per word across the MxV datapath.
    localparam int unsigned MXV_WORD_LENGTH = 8;

    // Streamer FSM state.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } mxv_state_e;

endpackage : mxv_pkg

// File: rtl/word_index_counter.sv
// Word index down-counter: loads Num_Words-1, decrements to 0 and stops there (no wrap).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        clock enable; 0 holds the count
//   clr_i       synchronous clear to 0 (highest priority)
//   load_i      load Num_Words-1
//   dec_i       decrement by one unless already 0
//   count_o     current index (registered)
//   is_zero_c   count_o == 0 (combinational from the register)
module word_index_counter #(
    parameter int unsigned Num_Words = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic                         clr_i,
    input  logic                         load_i,
    input  logic                         dec_i,
    output logic [$clog2(Num_Words)-1:0] count_o,
    output logic                         is_zero_c
);

    localparam int unsigned IW = $clog2(Num_Words);

    logic [IW-1:0] count_q;
    logic [IW-1:0] count_d;

    // Next count: clear > load > saturating decrement.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            if (clr_i) begin
                count_d = '0;
            end else if (load_i) begin
                count_d = IW'(Num_Words - 1);
            end else if (dec_i && (count_q != '0)) begin
                count_d = count_q - IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign is_zero_c = (count_q == '0);

endmodule : word_index_counter

// File: rtl/word_serializer.sv
// Parallel-in, serial-out word streamer: captures a flattened vector and replays it
// oldest-word-first (word Num_Words-1 first, word 0 last) over valid/ready.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   enable       clock enable; 0 freezes all state and outputs
//   Sync_Reset   synchronous clear to IDLE (qualified by enable)
//   load         capture request for Data_Input (honoured in IDLE only)
//   Data_Input   flattened vector; word k = bits [(k+1)*Word_Length-1 : k*Word_Length]
//   ready        downstream accepts the current word
//   Data_Output  current word (registered)
//   valid        Data_Output holds a word to transfer
//   busy         high while in SEND
//   done         one-cycle pulse after the last word transfers
module word_serializer
    import mxv_pkg::*;
#(
    parameter int unsigned Word_Length = MXV_WORD_LENGTH,
    parameter int unsigned Num_Words   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           Sync_Reset,
    input  logic                           load,
    input  logic [Word_Length*Num_Words-1:0] Data_Input,
    input  logic                           ready,
    output logic [Word_Length-1:0]         Data_Output,
    output logic                           valid,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned IW = $clog2(Num_Words);
    localparam int unsigned VW = Word_Length * Num_Words;

    mxv_state_e             state_q, state_d;
    logic [VW-1:0]          cap_q, cap_d;
    logic [Word_Length-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [IW-1:0]          index_q;
    logic [IW-1:0]          sel_idx;
    logic                   index_zero;
    logic                   cnt_clr, cnt_load, cnt_dec;

    word_index_counter #(
        .Num_Words (Num_Words)
    ) u_index (
        .clk       (clk),
        .rst_n     (reset),
        .en_i      (enable),
        .clr_i     (cnt_clr),
        .load_i    (cnt_load),
        .dec_i     (cnt_dec),
        .count_o   (index_q),
        .is_zero_c (index_zero)
    );

    // Word that follows the current one; only used when index_q > 0.
    assign sel_idx = index_q - IW'(1);

    // Next state and outputs: Sync_Reset > load > handshake, all gated by enable.
    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        if (enable) begin
            done_d = 1'b0;
            if (Sync_Reset) begin
                state_d = IDLE;
                cap_d   = '0;
                data_d  = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                cnt_clr = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        if (load) begin
                            cap_d    = Data_Input;
                            data_d   = Data_Input[(Num_Words-1)*Word_Length +: Word_Length];
                            valid_d  = 1'b1;
                            busy_d   = 1'b1;
                            cnt_load = 1'b1;
                            state_d  = SEND;
                        end
                    end
                    SEND: begin
                        // load is ignored here so the capture register stays intact.
                        if (valid_q && ready) begin
                            if (!index_zero) begin
                                cnt_dec = 1'b1;
                                data_d  = cap_q[32'(sel_idx) * Word_Length +: Word_Length];
                            end else begin
                                valid_d = 1'b0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Data_Output = data_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule : word_serializer

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer (Word_Length=8, Num_Words=8).
module tb_word_serializer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        Sync_Reset;
    logic        load;
    logic [63:0] Data_Input;
    logic        ready;
    logic [7:0]  Data_Output;
    logic        valid;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    logic [7:0] got_q[$];

    typedef struct {
        logic [63:0] data;
        logic [7:0]  exp [8];
    } vec_t;

    vec_t vecs [4];

    word_serializer #(
        .Word_Length (8),
        .Num_Words   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .Sync_Reset  (Sync_Reset),
        .load        (load),
        .Data_Input  (Data_Input),
        .ready       (ready),
        .Data_Output (Data_Output),
        .valid       (valid),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer monitor: a word moves at the next rising edge when these hold.
    always @(negedge clk) begin
        if (reset && enable && !Sync_Reset && valid && ready) begin
            got_q.push_back(Data_Output);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, 64'(valid), 64'd0);
        check({name, "_busy"},  64'(busy),  64'd0);
        check({name, "_done"},  64'(done),  64'd0);
        check({name, "_data"},  64'(Data_Output), 64'd0);
    endtask

    // Tick until done rises, bounded; an expired bound is a failed check.
    task automatic drain(input string name);
        for (int k = 0; k < 32 && !done; k++) tick();
        check({name, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic expect_stream(input string name, input logic [7:0] exp [8]);
        check({name, "_count"}, 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) check($sformatf("%s_w%0d", name, i), 64'(got_q[i]), 64'(exp[i]));
            else check($sformatf("%s_w%0d_missing", name, i), 64'd0, 64'd1);
        end
    endtask

    logic [7:0]  base_exp [8];
    logic [7:0]  seq_a [8];
    logic [7:0]  seq_b [8];
    logic [63:0] vec_a, vec_b;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0].data = 64'h0706050403020100;
        vecs[0].exp  = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        vecs[1].data = 64'h0123456789ABCDEF;
        vecs[1].exp  = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        vecs[2].data = 64'h80000000000000FF;
        vecs[2].exp  = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        vecs[3].data = 64'hA55A3CC30FF01EE1;
        vecs[3].exp  = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h1E, 8'hE1};
        base_exp     = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

        reset      = 1'b0;
        enable     = 1'b1;
        Sync_Reset = 1'b0;
        load       = 1'b0;
        Data_Input = '0;
        ready      = 1'b1;

        // Reset values, then no load keeps valid low.
        tick(); tick();
        check_idle_outputs("reset");
        reset = 1'b1;
        repeat (3) tick();
        check_idle_outputs("no_load");

        // Table-driven streams with ready high.
        for (int v = 0; v < 4; v++) begin
            load       = 1'b1;
            Data_Input = vecs[v].data;
            tick();
            load = 1'b0;
            for (int i = 0; i < 8; i++) begin
                check($sformatf("vec%0d_valid%0d", v, i), 64'(valid), 64'd1);
                check($sformatf("vec%0d_busy%0d",  v, i), 64'(busy),  64'd1);
                check($sformatf("vec%0d_word%0d",  v, i), 64'(Data_Output), 64'(vecs[v].exp[i]));
                tick();
            end
            check($sformatf("vec%0d_done", v),       64'(done),  64'd1);
            check($sformatf("vec%0d_end_valid", v),  64'(valid), 64'd0);
            check($sformatf("vec%0d_end_busy", v),   64'(busy),  64'd0);
            tick();
            check($sformatf("vec%0d_done_clear", v), 64'(done),  64'd0);
        end

        // Backpressure: stall three cycles on word 05.
        got_q.delete();
        load = 1'b1; Data_Input = 64'h0706050403020100;
        tick();
        load = 1'b0;
        tick(); tick();
        check("bp_at_05", 64'(Data_Output), 64'h05);
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("bp_hold_data%0d", s),  64'(Data_Output), 64'h05);
            check($sformatf("bp_hold_valid%0d", s), 64'(valid), 64'd1);
        end
        ready = 1'b1;
        drain("bp");
        expect_stream("bp_stream", base_exp);
        tick();

        // Load during SEND is ignored.
        got_q.delete();
        load = 1'b1; Data_Input = 64'h0706050403020100;
        tick();
        load = 1'b0;
        repeat (3) tick();
        check("ls_at_04", 64'(Data_Output), 64'h04);
        load = 1'b1; Data_Input = 64'hFFFFFFFFFFFFFFFF;
        tick();
        load = 1'b0; Data_Input = '0;
        drain("ls");
        expect_stream("ls_stream", base_exp);
        tick();

        // Enable low for two cycles mid-stream, and freezing the done pulse.
        got_q.delete();
        load = 1'b1; Data_Input = 64'h0706050403020100;
        tick();
        load = 1'b0;
        repeat (4) tick();
        check("en_at_03", 64'(Data_Output), 64'h03);
        enable = 1'b0;
        for (int s = 0; s < 2; s++) begin
            tick();
            check($sformatf("en_hold_data%0d", s),  64'(Data_Output), 64'h03);
            check($sformatf("en_hold_valid%0d", s), 64'(valid), 64'd1);
            check($sformatf("en_hold_busy%0d", s),  64'(busy),  64'd1);
        end
        enable = 1'b1;
        tick();
        check("en_resume_02", 64'(Data_Output), 64'h02);
        drain("en");
        enable = 1'b0;
        tick();
        check("en_done_frozen", 64'(done), 64'd1);
        enable = 1'b1;
        tick();
        check("en_done_clear", 64'(done), 64'd0);
        expect_stream("en_stream", base_exp);

        // Sync_Reset wins over a simultaneous load.
        load = 1'b1; Data_Input = 64'h0706050403020100;
        tick();
        load = 1'b0;
        tick();
        Sync_Reset = 1'b1; load = 1'b1; Data_Input = 64'h1111111111111111;
        tick();
        Sync_Reset = 1'b0; load = 1'b0;
        check_idle_outputs("srst");
        repeat (2) tick();
        check_idle_outputs("srst_after");

        // Async reset mid-SEND aborts immediately with no done pulse.
        load = 1'b1; Data_Input = 64'h0706050403020100;
        tick();
        load = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check_idle_outputs("areset");
        tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("areset_after");

        // Round trip: words shifted in oldest-high come back out oldest-first, back-to-back.
        seq_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        seq_b = '{8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78};
        vec_a = '0;
        vec_b = '0;
        for (int i = 0; i < 8; i++) begin
            vec_a = {vec_a[55:0], seq_a[i]};
            vec_b = {vec_b[55:0], seq_b[i]};
        end
        got_q.delete();
        load = 1'b1; Data_Input = vec_a;
        tick();
        load = 1'b0;
        repeat (8) tick();
        check("b2b_done", 64'(done), 64'd1);
        load = 1'b1; Data_Input = vec_b;
        tick();
        load = 1'b0;
        check("b2b_valid",      64'(valid), 64'd1);
        check("b2b_first_word", 64'(Data_Output), 64'(seq_b[0]));
        check("b2b_done_clear", 64'(done), 64'd0);
        drain("b2b");
        check("rt_count", 64'(got_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < got_q.size())
                check($sformatf("rt_w%0d", i), 64'(got_q[i]), 64'(i < 8 ? seq_a[i] : seq_b[i-8]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_word_serializer
